// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, register map, status bits
// and AXI response codes. The receiver imports this package as well.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_RELEASE
  } ps2_state_t;

  localparam logic [15:0] REG_TXDATA = 16'h0000;
  localparam logic [15:0] REG_STATUS = 16'h0004;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_NACK    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_DONE    = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines, plus a
// falling-edge detector on the synchronized clock.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to the idle-high bus level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_i};
      data_ff  <= {data_ff[0], ps2_data_i};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s    = clk_ff[1];
  assign data_s   = data_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter with an AXI-lite register slave: inhibit,
// request-to-send, frame shift under device clock, ACK check and timeout.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [15:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        busy
);

  ps2_state_t  state, state_next;
  logic        clk_s, data_s, clk_fall;
  logic [31:0] cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  frame;
  logic [7:0]  tx_byte;
  logic        data_bit;
  logic        nack_q, timeout_q, done_q;
  logic        ack_sample, tmo_abort, in_line, timeout_hit;
  logic        axi_ready, wr_fire, is_txdata, start;
  logic [31:0] status_word;
  logic        unused_inputs;

  ps2_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_s     (clk_s),
    .data_s    (data_s),
    .clk_fall  (clk_fall)
  );

  assign unused_inputs = ^{awprot, arprot, awaddr[15:4], awaddr[1:0],
                           araddr[15:4], araddr[1:0], wdata[31:8], wstrb[3:1]};

  assign wr_fire     = axi_ready && awvalid && wvalid;
  assign is_txdata   = (awaddr[3:2] == REG_TXDATA[3:2]);
  assign start       = wr_fire && is_txdata && wstrb[0] && (state == ST_IDLE);
  assign in_line     = (state == ST_SEND) || (state == ST_ACK) || (state == ST_RELEASE);
  assign timeout_hit = (cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_next = state;
    ack_sample = 1'b0;
    tmo_abort  = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_next = ST_INHIBIT;
      ST_INHIBIT: if (cnt == INHIBIT_CYCLES - 1) state_next = ST_REQ;
      ST_REQ:     state_next = ST_SEND;
      ST_SEND: begin
        if (clk_fall && bit_cnt == 4'd9) state_next = ST_ACK;
        else if (!clk_fall && timeout_hit) tmo_abort = 1'b1;
      end
      ST_ACK: begin
        if (clk_fall) begin
          ack_sample = 1'b1;
          state_next = ST_RELEASE;
        end else if (timeout_hit) begin
          tmo_abort = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (clk_s && data_s) state_next = ST_IDLE;
        else if (!clk_fall && timeout_hit) tmo_abort = 1'b1;
      end
      default:    state_next = ST_IDLE;
    endcase
    if (tmo_abort) state_next = ST_IDLE;
  end

  // One counter times both the inhibit phase and the device-clock watchdog;
  // it restarts on every state change and on device clock edges on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      data_bit  <= 1'b0;
      frame     <= '0;
      tx_byte   <= '0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || (in_line && clk_fall)) cnt <= '0;
      else if (state != ST_IDLE) cnt <= cnt + 32'd1;
      if (start) begin
        tx_byte   <= wdata[7:0];
        frame     <= {1'b1, odd_parity(wdata[7:0]), wdata[7:0]};
        nack_q    <= 1'b0;
        timeout_q <= 1'b0;
        done_q    <= 1'b0;
      end
      if (state == ST_REQ) begin
        bit_cnt  <= '0;
        data_bit <= 1'b1;
      end else if (state == ST_SEND && clk_fall) begin
        data_bit <= ~frame[bit_cnt];
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (ack_sample) begin
        done_q <= 1'b1;
        nack_q <= data_s;
      end
      if (tmo_abort) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
  assign ps2_data_oe = (state == ST_REQ) || ((state == ST_SEND) && data_bit);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = busy;
    status_word[STAT_NACK]    = nack_q;
    status_word[STAT_TIMEOUT] = timeout_q;
    status_word[STAT_DONE]    = done_q;
  end

  // Write channel: AW and W are accepted together, one outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_ready <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      axi_ready <= awvalid && wvalid && !bvalid && !axi_ready;
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= (is_txdata && wstrb[0] && state != ST_IDLE) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  assign awready = axi_ready;
  assign wready  = axi_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= arvalid && !rvalid && !arready;
      if (arready && arvalid) begin
        rvalid <= 1'b1;
        if (araddr[3:2] == REG_TXDATA[3:2])      rdata <= {24'b0, tx_byte};
        else if (araddr[3:2] == REG_STATUS[3:2]) rdata <= status_word;
        else                                     rdata <= '0;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign rresp = RESP_OKAY;

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: an AXI-lite master, a behavioural PS/2
// device and a frame/status reference model computed from the byte value.
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        ps2_clk_i, ps2_data_i;
  logic        ps2_clk_oe, ps2_data_oe, busy;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy)
  );

  // Reference frame as the device sees it: start 0, byte LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold, output logic [1:0] resp, output bit stable, output bit ok);
    int n;
    ok = 1; stable = 1; resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = (hold == 0);
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) ok = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) begin ok = 0; bready = 1; return; end
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bvalid || bresp !== resp) stable = 0;
    end
    bready = 1;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int hold,
                          output logic [31:0] data, output bit stable, output bit ok);
    int n;
    ok = 1; stable = 1; data = 'x;
    @(negedge clk);
    araddr = addr; arvalid = 1; rready = (hold == 0);
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) ok = 0;
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) begin ok = 0; rready = 1; return; end
    data = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rvalid || rdata !== data) stable = 0;
    end
    rready = 1;
    @(negedge clk);
  endtask

  // Behavioural device: waits for request-to-send, clocks 10 bits sampling
  // at the end of each low phase, then returns ack_bit on the 11th clock.
  task automatic device(input bit ack_bit, input int half, input int abort_at,
                        output logic [10:0] bits, output bit ok);
    int n;
    bits = '0; ok = 1; n = 0;
    while (!(ps2_clk_i && !ps2_data_i) && n < 300) begin @(negedge clk); n++; end
    if (!(ps2_clk_i && !ps2_data_i)) begin ok = 0; return; end
    bits[0] = ps2_data_i;
    repeat (half) @(negedge clk);
    for (int e = 1; e <= 10; e++) begin
      dev_clk_low = 1;
      repeat (half) @(negedge clk);
      if (e == abort_at) return;
      bits[e] = ps2_data_i;
      dev_clk_low = 0;
      repeat (half) @(negedge clk);
    end
    dev_data_low = ~ack_bit;
    repeat (2) @(negedge clk);
    dev_clk_low = 1;
    repeat (half) @(negedge clk);
    dev_clk_low = 0;
    repeat (2) @(negedge clk);
    dev_data_low = 0;
    repeat (half) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    vectors++;
    if (busy) begin miscompares++; $display("[TB] FAIL %s idle wait: busy still %b after %0d cycles", name, busy, n); end
  endtask

  // Runs one full transfer with the device model and checks frame, response and STATUS.
  task automatic run_transfer(input string name, input logic [7:0] b, input bit ack_bit, input int half);
    logic [1:0] resp; logic [10:0] bits; logic [31:0] st; bit s, ok, dok, rok;
    fork
      axi_write(16'h0, {24'h0, b}, 4'h1, 0, resp, s, ok);
      device(ack_bit, half, 0, bits, dok);
    join
    vectors++; if (!ok || !dok) begin miscompares++; $display("[TB] FAIL %s handshake: write_ok=%b device_ok=%b required 1/1", name, ok, dok); end
    vectors++; if (resp !== 2'b00) begin miscompares++; $display("[TB] FAIL %s bresp: got %b required 00", name, resp); end
    vectors++; if (bits !== exp_frame(b)) begin miscompares++; $display("[TB] FAIL %s frame: got %b required %b", name, bits, exp_frame(b)); end
    wait_idle(name);
    axi_read(16'h4, 0, st, s, rok);
    vectors++; if (st !== (ack_bit ? 32'hA : 32'h8) || !rok) begin miscompares++; $display("[TB] FAIL %s status: got %h required %h", name, st, ack_bit ? 32'hA : 32'h8); end
  endtask

  task automatic test_reset();
    logic [31:0] d; bit s, ok;
    rst = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, arready, rvalid, ps2_clk_oe, ps2_data_oe, busy} !== 8'h00 ||
        bresp !== 2'b00 || rdata !== 32'h0 || rresp !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: got ctl=%b bresp=%b rdata=%h rresp=%b required all zero",
               {awready, wready, bvalid, arready, rvalid, ps2_clk_oe, ps2_data_oe, busy}, bresp, rdata, rresp);
    end
    rst = 0;
    axi_read(16'h4, 0, d, s, ok);
    vectors++; if (d !== 32'h0 || !ok) begin miscompares++; $display("[TB] FAIL reset status: got %h required 0", d); end
    axi_read(16'h0, 0, d, s, ok);
    vectors++; if (d !== 32'h0 || !ok) begin miscompares++; $display("[TB] FAIL reset txdata: got %h required 0", d); end
  endtask

  task automatic test_inhibit_ack();
    logic [1:0] resp; logic [10:0] bits; logic [31:0] st; bit s, ok, dok, rok;
    int inh, req, n; logic start_ok;
    inh = 0; req = 0; start_ok = 0;
    fork
      axi_write(16'h0, 32'hED, 4'h1, 0, resp, s, ok);
      device(1'b0, 8, 0, bits, dok);
      begin
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin inh++; @(negedge clk); end
        while (ps2_clk_oe && ps2_data_oe && req < 1000) begin req++; @(negedge clk); end
        start_ok = !ps2_clk_oe && ps2_data_oe;
      end
    join
    vectors++; if (inh !== INH) begin miscompares++; $display("[TB] FAIL inhibit length: got %0d required %0d", inh, INH); end
    vectors++; if (req !== 1) begin miscompares++; $display("[TB] FAIL request length: got %0d required 1", req); end
    vectors++; if (start_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL start bit: got %b required 1", start_ok); end
    vectors++; if (!ok || !dok || resp !== 2'b00) begin miscompares++; $display("[TB] FAIL ED bresp: got %b ok=%b/%b required 00", resp, ok, dok); end
    vectors++; if (bits !== exp_frame(8'hED)) begin miscompares++; $display("[TB] FAIL ED frame: got %b required %b", bits, exp_frame(8'hED)); end
    wait_idle("ED");
    axi_read(16'h4, 0, st, s, rok);
    vectors++; if (st !== 32'h8 || !rok) begin miscompares++; $display("[TB] FAIL ED status: got %h required 8", st); end
  endtask

  task automatic test_nack();
    run_transfer("FF nack", 8'hFF, 1'b1, 8);
  endtask

  task automatic test_timeout();
    logic [1:0] resp; logic [31:0] st; bit s, ok, rok; int n, held;
    held = 0;
    fork
      axi_write(16'h0, 32'hF4, 4'h1, 0, resp, s, ok);
      begin
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        while (ps2_data_oe && held < 1000) begin held++; @(negedge clk); end
      end
    join
    vectors++; if (held !== TMO) begin miscompares++; $display("[TB] FAIL timeout release: got %0d cycles required %0d", held, TMO); end
    wait_idle("timeout");
    axi_read(16'h4, 0, st, s, rok);
    vectors++; if (st !== 32'hC || !rok || !ok) begin miscompares++; $display("[TB] FAIL timeout status: got %h required c", st); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r1, r2; logic [10:0] bits; logic [31:0] st; bit s, ok1, ok2, dok, rok; int n;
    fork
      begin
        axi_write(16'h0, 32'h55, 4'h1, 0, r1, s, ok1);
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        axi_write(16'h0, 32'h33, 4'h1, 0, r2, s, ok2);
      end
      device(1'b0, 8, 0, bits, dok);
    join
    vectors++; if (r1 !== 2'b00 || !ok1) begin miscompares++; $display("[TB] FAIL first write bresp: got %b required 00", r1); end
    vectors++; if (r2 !== 2'b10 || !ok2) begin miscompares++; $display("[TB] FAIL busy write bresp: got %b required 10", r2); end
    vectors++; if (bits !== exp_frame(8'h55) || !dok) begin miscompares++; $display("[TB] FAIL 55 frame: got %b required %b", bits, exp_frame(8'h55)); end
    wait_idle("55");
    axi_read(16'h0, 0, st, s, rok);
    vectors++; if (st !== 32'h55 || !rok) begin miscompares++; $display("[TB] FAIL txdata after busy write: got %h required 55", st); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [10:0] bits; logic [31:0] st; bit s, ok, dok, rok; logic [7:0] b;
    b = 8'($urandom);
    fork
      axi_write(16'h0, {24'h0, b}, 4'h1, 0, resp, s, ok);
      device(1'b0, 8, 5, bits, dok);
    join
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    vectors++; if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin miscompares++; $display("[TB] FAIL mid reset lines: got oe=%b%b busy=%b required 000", ps2_clk_oe, ps2_data_oe, busy); end
    rst = 0;
    dev_clk_low = 0;
    axi_read(16'h4, 0, st, s, rok);
    vectors++; if (st !== 32'h0 || !rok) begin miscompares++; $display("[TB] FAIL mid reset status: got %h required 0", st); end
    repeat (5) @(negedge clk);
    run_transfer("AA after reset", 8'hAA, 1'b0, 8);
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [31:0] d; bit s, ok; int n;
    axi_read(16'h0, 5, d, s, ok);
    vectors++; if (d !== 32'h000000AA || !ok) begin miscompares++; $display("[TB] FAIL held read data: got %h required 000000aa", d); end
    vectors++; if (s !== 1'b1) begin miscompares++; $display("[TB] FAIL rvalid hold: stable=%b required 1", s); end
    axi_write(16'h4, $urandom, 4'hF, 5, resp, s, ok);
    vectors++; if (resp !== 2'b00 || !ok || s !== 1'b1) begin miscompares++; $display("[TB] FAIL held status write: bresp=%b stable=%b required 00/1", resp, s); end
    axi_write(16'h0, 32'h12, 4'h0, 0, resp, s, ok);
    n = busy;
    vectors++; if (resp !== 2'b00 || n !== 0 || !ok) begin miscompares++; $display("[TB] FAIL strobe-off write: bresp=%b busy=%0d required 00/0", resp, n); end
  endtask

  task automatic test_random();
    logic [7:0] b; bit a; int h;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      h = int'($urandom_range(5, 12));
      run_transfer($sformatf("random %0d byte %h", i, b), b, a, h);
    end
  endtask

  initial begin
    test_reset();
    test_inhibit_ack();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
